// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAMController between the MEM stage (port 0)
// and a secondary memory master (port 1). One command is latched per grant
// and held on ctrl_* until the controller's ready pulse or a watchdog abort.
//
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   - round-robin arbitration with a 1-bit preferred-port pointer
//   undefined - fixed priority, port 0 wins
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   mX_read_en/mX_write_en      port X request (both high = write)
//   mX_addr/mX_wdata            port X command
//   mX_rdata/mX_ready           port X load data / not-stalled (combinational)
//   ctrl_read_en/write_en/addr/wdata   registered command to the controller
//   ctrl_rdata/ctrl_ready       controller response, ready is a 1-cycle pulse
//   grant                       one-hot owner, 00 when idle
//   timeout_err                 sticky watchdog abort flag
module sram_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_read_en,
  input  logic        m0_write_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_read_en,
  input  logic        m1_write_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        ctrl_read_en,
  output logic        ctrl_write_en,
  output logic [31:0] ctrl_addr,
  output logic [31:0] ctrl_wdata,
  input  logic [31:0] ctrl_rdata,
  input  logic        ctrl_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              ctrl_rd_q, ctrl_rd_d;
  logic              ctrl_wr_q, ctrl_wr_d;
  logic [DW-1:0]     ctrl_addr_q, ctrl_addr_d;
  logic [DW-1:0]     ctrl_wdata_q, ctrl_wdata_d;
  logic [DW-1:0]     rdata0_q, rdata0_d;
  logic [DW-1:0]     rdata1_q, rdata1_d;
  logic              terr_q, terr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic          req0_c, req1_c, win1_c;
  logic          done_c, timeout_c, finish_c, read_resp_c;
  logic [DW-1:0] resp_data_c;

  assign req0_c = m0_read_en | m0_write_en;
  assign req1_c = m1_read_en | m1_write_en;

  // Port 1 wins only when port 0 is silent, or when the pointer prefers it.
`ifdef SRAM_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign win1_c = req1_c & (~req0_c | ptr_q);
`else
  assign win1_c = req1_c & ~req0_c;
`endif

  // Completion wins over a watchdog expiry landing in the same cycle.
  assign done_c      = (state_q == BUSY) & ctrl_ready;
  assign timeout_c   = (TIMEOUT != 0) & (state_q == BUSY) & ~ctrl_ready &
                       (cnt_q == CNT_W'(TIMEOUT));
  assign finish_c    = done_c | timeout_c;
  assign read_resp_c = finish_c & ctrl_rd_q;
  assign resp_data_c = ctrl_ready ? ctrl_rdata : ABORT_DATA;

  // Ready and read data bypass in the completion cycle so MEM/WB captures it.
  assign m0_ready = ~req0_c | (grant_q[0] & finish_c);
  assign m1_ready = ~req1_c | (grant_q[1] & finish_c);
  assign m0_rdata = (grant_q[0] & read_resp_c) ? resp_data_c : rdata0_q;
  assign m1_rdata = (grant_q[1] & read_resp_c) ? resp_data_c : rdata1_q;

  assign ctrl_read_en  = ctrl_rd_q;
  assign ctrl_write_en = ctrl_wr_q;
  assign ctrl_addr     = ctrl_addr_q;
  assign ctrl_wdata    = ctrl_wdata_q;
  assign grant         = grant_q;
  assign timeout_err   = terr_q;

  // Next-state and command/response register updates.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ctrl_rd_d    = ctrl_rd_q;
    ctrl_wr_d    = ctrl_wr_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_wdata_d = ctrl_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    terr_d       = terr_q;
    cnt_d        = cnt_q;
`ifdef SRAM_ARB_RR_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        ctrl_rd_d = 1'b0;
        ctrl_wr_d = 1'b0;
        grant_d   = 2'b00;
        if (req0_c | req1_c) begin
          // A write takes precedence when both enables are set.
          if (win1_c) begin
            ctrl_wr_d    = m1_write_en;
            ctrl_rd_d    = m1_read_en & ~m1_write_en;
            ctrl_addr_d  = m1_addr;
            ctrl_wdata_d = m1_wdata;
            grant_d      = 2'b10;
          end else begin
            ctrl_wr_d    = m0_write_en;
            ctrl_rd_d    = m0_read_en & ~m0_write_en;
            ctrl_addr_d  = m0_addr;
            ctrl_wdata_d = m0_wdata;
            grant_d      = 2'b01;
          end
          cnt_d   = '0;
          state_d = BUSY;
`ifdef SRAM_ARB_RR_EN
          ptr_d   = ~win1_c;
`endif
        end
      end
      BUSY: begin
        if (finish_c) begin
          if (read_resp_c & grant_q[0]) rdata0_d = resp_data_c;
          if (read_resp_c & grant_q[1]) rdata1_d = resp_data_c;
          if (timeout_c) terr_d = 1'b1;
          ctrl_rd_d = 1'b0;
          ctrl_wr_d = 1'b0;
          grant_d   = 2'b00;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      ctrl_rd_q    <= 1'b0;
      ctrl_wr_q    <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_wdata_q <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      terr_q       <= 1'b0;
      cnt_q        <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ctrl_rd_q    <= ctrl_rd_d;
      ctrl_wr_q    <= ctrl_wr_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_wdata_q <= ctrl_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      terr_q       <= terr_d;
      cnt_q        <= cnt_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (default build, TIMEOUT = 8).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_read_en = 1'b0, m0_write_en = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m1_read_en = 1'b0, m1_write_en = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        ctrl_read_en, ctrl_write_en;
  logic [31:0] ctrl_addr, ctrl_wdata;
  logic [31:0] ctrl_rdata = '0;
  logic        ctrl_ready = 1'b0;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_read_en(m0_read_en), .m0_write_en(m0_write_en),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_read_en(m1_read_en), .m1_write_en(m1_write_en),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .ctrl_read_en(ctrl_read_en), .ctrl_write_en(ctrl_write_en),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_rdata(ctrl_rdata), .ctrl_ready(ctrl_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ctrl_rd", 32'(ctrl_read_en), 32'h0);
    chk("rst_ctrl_wr", 32'(ctrl_write_en), 32'h0);
    chk("rst_ctrl_addr", ctrl_addr, 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m0_ready", 32'(m0_ready), 32'h1);
    step();
    rst = 1'b1;
    step();

    // Port 0 read of 0x400, response 6 cycles after the command appears
    m0_read_en = 1'b1; m0_addr = 32'h400;
    #1;
    chk("t1_ready_idle", 32'(m0_ready), 32'h0);
    chk("t1_grant_idle", 32'(grant), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step(); #1;
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_ctrl_rd", 32'(ctrl_read_en), 32'h1);
      chk("t1_ctrl_addr", ctrl_addr, 32'h400);
      chk("t1_ready_busy", 32'(m0_ready), 32'h0);
    end
    step();
    ctrl_ready = 1'b1; ctrl_rdata = 32'h12345678;
    #1;
    chk("t1_ready_done", 32'(m0_ready), 32'h1);
    chk("t1_rdata_bypass", m0_rdata, 32'h12345678);
    step();
    ctrl_ready = 1'b0; ctrl_rdata = 32'h0; m0_read_en = 1'b0;
    #1;
    chk("t1_grant_after", 32'(grant), 32'h0);
    chk("t1_ctrl_rd_after", 32'(ctrl_read_en), 32'h0);
    chk("t1_rdata_held", m0_rdata, 32'h12345678);

    // Contention: port 0 write wins, port 1 read follows after one IDLE cycle
    m0_write_en = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA5A5A5A5;
    m1_read_en = 1'b1;  m1_addr = 32'h20;
    #1;
    chk("t2_m0_ready_idle", 32'(m0_ready), 32'h0);
    chk("t2_m1_ready_idle", 32'(m1_ready), 32'h0);
    step(); #1;
    chk("t2_grant0", 32'(grant), 32'h1);
    chk("t2_ctrl_wr", 32'(ctrl_write_en), 32'h1);
    chk("t2_ctrl_addr0", ctrl_addr, 32'h10);
    chk("t2_ctrl_wdata", ctrl_wdata, 32'hA5A5A5A5);
    step();
    ctrl_ready = 1'b1; ctrl_rdata = 32'hFFFF0000;
    #1;
    chk("t2_m0_ready_done", 32'(m0_ready), 32'h1);
    chk("t2_m1_ready_wait", 32'(m1_ready), 32'h0);
    chk("t2_m0_rdata_wr", m0_rdata, 32'h12345678);
    step();
    ctrl_ready = 1'b0; m0_write_en = 1'b0;
    #1;
    chk("t2_idle_gap", 32'(grant), 32'h0);
    chk("t2_m1_ready_gap", 32'(m1_ready), 32'h0);
    step(); #1;
    chk("t2_grant1", 32'(grant), 32'h2);
    chk("t2_ctrl_addr1", ctrl_addr, 32'h20);
    chk("t2_ctrl_rd1", 32'(ctrl_read_en), 32'h1);

    // Port 1 address change mid-BUSY must not disturb the latched command
    m1_addr = 32'h30;
    step(); #1;
    chk("t3_addr_stable", ctrl_addr, 32'h20);
    step();
    ctrl_ready = 1'b1; ctrl_rdata = 32'hCAFEF00D;
    #1;
    chk("t3_m1_ready", 32'(m1_ready), 32'h1);
    chk("t3_m1_rdata", m1_rdata, 32'hCAFEF00D);
    chk("t3_m0_rdata_keep", m0_rdata, 32'h12345678);
    step();
    ctrl_ready = 1'b0; ctrl_rdata = 32'h0; m1_read_en = 1'b0;
    #1;
    chk("t3_grant_after", 32'(grant), 32'h0);
    chk("t3_m1_rdata_held", m1_rdata, 32'hCAFEF00D);

    // Watchdog: no ctrl_ready, abort on the 9th BUSY cycle (counter reaches 8)
    m0_read_en = 1'b1; m0_addr = 32'h44;
    for (int k = 1; k <= 8; k++) begin
      step(); #1;
      chk("t4_ready_wait", 32'(m0_ready), 32'h0);
      chk("t4_terr_wait", 32'(timeout_err), 32'h0);
    end
    step(); #1;
    chk("t4_ready_pulse", 32'(m0_ready), 32'h1);
    chk("t4_rdata_abort", m0_rdata, 32'hDEADBEEF);
    step();
    m0_read_en = 1'b0;
    #1;
    chk("t4_terr_set", 32'(timeout_err), 32'h1);
    chk("t4_grant_idle", 32'(grant), 32'h0);
    chk("t4_ctrl_rd_off", 32'(ctrl_read_en), 32'h0);
    chk("t4_rdata_held", m0_rdata, 32'hDEADBEEF);

    // Both enables high: treated as a write, rdata untouched
    m0_read_en = 1'b1; m0_write_en = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h11112222;
    step(); #1;
    chk("t6_ctrl_wr", 32'(ctrl_write_en), 32'h1);
    chk("t6_ctrl_rd", 32'(ctrl_read_en), 32'h0);
    step();
    ctrl_ready = 1'b1; ctrl_rdata = 32'h99999999;
    #1;
    chk("t6_ready", 32'(m0_ready), 32'h1);
    chk("t6_rdata_keep", m0_rdata, 32'hDEADBEEF);
    step();
    ctrl_ready = 1'b0; m0_read_en = 1'b0; m0_write_en = 1'b0;
    #1;
    chk("t6_terr_sticky", 32'(timeout_err), 32'h1);

    // Asynchronous reset in the middle of a port 1 access
    m1_read_en = 1'b1; m1_addr = 32'h50;
    step(); #1;
    chk("t5_grant_busy", 32'(grant), 32'h2);
    #1 rst = 1'b0;
    #1;
    chk("t5_grant_rst", 32'(grant), 32'h0);
    chk("t5_ctrl_rd_rst", 32'(ctrl_read_en), 32'h0);
    chk("t5_terr_rst", 32'(timeout_err), 32'h0);
    chk("t5_m1_rdata_rst", m1_rdata, 32'h0);
    m1_read_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    m1_read_en = 1'b1; m1_addr = 32'h60;
    step(); #1;
    chk("t5_regrant", 32'(grant), 32'h2);
    chk("t5_ctrl_addr", ctrl_addr, 32'h60);
    step();
    ctrl_ready = 1'b1; ctrl_rdata = 32'h0BADF00D;
    #1;
    chk("t5_m1_ready", 32'(m1_ready), 32'h1);
    chk("t5_m1_rdata", m1_rdata, 32'h0BADF00D);
    step();
    ctrl_ready = 1'b0; m1_read_en = 1'b0;
    #1;
    chk("t5_final_idle", 32'(grant), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
